// File: rtl/aes_block_uart_serializer_if.sv
// Block handshake between the AES result stage and the UART serializer.
// The master offers a block with valid/data; the slave answers with ready.
interface aes_block_uart_serializer_if #(
  parameter int BLOCK_BYTES = 16
);
  logic                     blk_valid;
  logic [8*BLOCK_BYTES-1:0] blk_data;
  logic                     blk_ready;

  modport master (output blk_valid, output blk_data, input blk_ready);
  modport slave  (input blk_valid, input blk_data, output blk_ready);
endinterface

// File: rtl/aes_block_uart_serializer.sv
// Slices one AES result block into bytes and feeds them, one at a time, to a
// level-start / ready UART transmitter. The next byte waits for full completion.
module aes_block_uart_serializer #(
  parameter int BLOCK_BYTES = 16,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                              uart_clock,
  input  logic                              uart_reset,
  aes_block_uart_serializer_if.slave        blk,
  output logic                              tx_start,
  output logic [7:0]                        tx_data,
  input  logic                              tx_ready,
  output logic                              busy,
  output logic [3:0]                        byte_idx,
  output logic                              done,
  output logic                              err
);
  localparam int W  = 8 * BLOCK_BYTES;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [3:0]    LAST_IDX = 4'(BLOCK_BYTES - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP_CYCLES);
  localparam logic [TW-1:0] TO_END   = TW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_GAP       = 2'd1,
    S_START     = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  function automatic logic [7:0] head_byte(input logic [W-1:0] v);
    if (MSB_FIRST) head_byte = v[W-1 -: 8];
    else           head_byte = v[7:0];
  endfunction

  function automatic logic [W-1:0] next_shift(input logic [W-1:0] v);
    if (MSB_FIRST) next_shift = v << 4'd8;
    else           next_shift = v >> 4'd8;
  endfunction

  state_t        state_r, state_nx_s;
  logic [W-1:0]  shift_r, shift_nx_s;
  logic [GW-1:0] gap_r, gap_nx_s;
  logic [TW-1:0] to_r, to_nx_s, to_inc_s;
  logic [3:0]    byte_idx_r, byte_idx_nx_s;
  logic [7:0]    tx_data_r, tx_data_nx_s;
  logic          tx_start_r, tx_start_nx_s;
  logic          blk_ready_r, blk_ready_nx_s;
  logic          busy_r, busy_nx_s;
  logic          done_r, done_nx_s;
  logic          err_r, err_nx_s;

  // Next-state and next-output logic for the byte sequencer.
  always_comb begin
    state_nx_s     = state_r;
    shift_nx_s     = shift_r;
    gap_nx_s       = gap_r;
    to_nx_s        = to_r;
    to_inc_s       = to_r + TW'(1'b1);
    byte_idx_nx_s  = byte_idx_r;
    tx_data_nx_s   = tx_data_r;
    tx_start_nx_s  = tx_start_r;
    blk_ready_nx_s = blk_ready_r;
    busy_nx_s      = busy_r;
    done_nx_s      = 1'b0;
    err_nx_s       = err_r;
    case (state_r)
      S_IDLE: begin
        blk_ready_nx_s = 1'b1;
        tx_start_nx_s  = 1'b0;
        busy_nx_s      = 1'b0;
        if (blk.blk_valid && blk_ready_r) begin
          shift_nx_s     = blk.blk_data;
          tx_data_nx_s   = head_byte(blk.blk_data);
          err_nx_s       = 1'b0;
          busy_nx_s      = 1'b1;
          byte_idx_nx_s  = 4'd0;
          gap_nx_s       = {GW{1'b0}};
          blk_ready_nx_s = 1'b0;
          state_nx_s     = S_GAP;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_GAP: begin
        // The gap only counts clocks where the transmitter reports idle.
        if (!tx_ready) begin
          gap_nx_s = {GW{1'b0}};
        end else if (gap_r >= GAP_END) begin
          to_nx_s       = {TW{1'b0}};
          tx_start_nx_s = 1'b1;
          state_nx_s    = S_START;
        end else begin
          gap_nx_s = gap_r + GW'(1'b1);
        end
      end
      S_START: begin
        if (!tx_ready) begin
          tx_start_nx_s = 1'b0;
          state_nx_s    = S_WAIT_DONE;
        end else if (to_inc_s == TO_END) begin
          err_nx_s       = 1'b1;
          tx_start_nx_s  = 1'b0;
          busy_nx_s      = 1'b0;
          blk_ready_nx_s = 1'b1;
          state_nx_s     = S_IDLE;
        end else begin
          to_nx_s = to_inc_s;
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready) begin
          if (byte_idx_r == LAST_IDX) begin
            done_nx_s      = 1'b1;
            busy_nx_s      = 1'b0;
            blk_ready_nx_s = 1'b1;
            state_nx_s     = S_IDLE;
          end else begin
            shift_nx_s    = next_shift(shift_r);
            tx_data_nx_s  = head_byte(next_shift(shift_r));
            byte_idx_nx_s = byte_idx_r + 4'd1;
            gap_nx_s      = {GW{1'b0}};
            state_nx_s    = S_GAP;
          end
        end else begin
          state_nx_s = S_WAIT_DONE;
        end
      end
      default: begin
        tx_start_nx_s  = 1'b0;
        busy_nx_s      = 1'b0;
        blk_ready_nx_s = 1'b1;
        state_nx_s     = S_IDLE;
      end
    endcase
  end

  // State and registered-output flops; reset discards any block in flight.
  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      state_r     <= S_IDLE;
      shift_r     <= {W{1'b0}};
      gap_r       <= {GW{1'b0}};
      to_r        <= {TW{1'b0}};
      byte_idx_r  <= 4'd0;
      tx_data_r   <= 8'h00;
      tx_start_r  <= 1'b0;
      blk_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      shift_r     <= shift_nx_s;
      gap_r       <= gap_nx_s;
      to_r        <= to_nx_s;
      byte_idx_r  <= byte_idx_nx_s;
      tx_data_r   <= tx_data_nx_s;
      tx_start_r  <= tx_start_nx_s;
      blk_ready_r <= blk_ready_nx_s;
      busy_r      <= busy_nx_s;
      done_r      <= done_nx_s;
      err_r       <= err_nx_s;
    end
  end

  assign blk.blk_ready = blk_ready_r;
  assign tx_start      = tx_start_r;
  assign tx_data       = tx_data_r;
  assign busy          = busy_r;
  assign byte_idx      = byte_idx_r;
  assign done          = done_r;
  assign err           = err_r;
endmodule

// File: tb/tb_aes_block_uart_serializer.sv
// Directed bench: two serializers (MSB-first and LSB-first) in lockstep, each
// driving a behavioural level-start transmitter with a 40-clock frame.
module tb_aes_block_uart_serializer;
  localparam int FRAME = 40;
  localparam logic [127:0] BLK_A  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] BLK_B1 = 128'h0102030405060708090A0B0C0D0E0F10;
  localparam logic [127:0] BLK_B2 = 128'hF1E2D3C4B5A69788796A5B4C3D2E1F00;
  localparam logic [127:0] BLK_C  = 128'hA5B6C7D8E9FA0B1C2D3E4F5061728394;

  logic         uart_clock = 1'b0;
  logic         uart_reset = 1'b1;
  logic         blk_valid  = 1'b0;
  logic [127:0] blk_data   = 128'h0;
  logic         stuck      = 1'b0;
  int           n_vec      = 0;
  int           n_miss     = 0;

  always #5 uart_clock = ~uart_clock;

  for (genvar g = 0; g < 2; g++) begin : ch
    aes_block_uart_serializer_if #(.BLOCK_BYTES(16)) bif ();
    logic       tx_start, tx_ready, busy, done, err;
    logic [7:0] tx_data;
    logic [3:0] byte_idx;
    logic [1:0] low_hist;
    logic       busy_m;
    int         frame_cnt;
    logic [7:0] lat;
    logic [7:0] sent_q[$];
    logic [3:0] idx_q[$];
    int         done_cnt = 0;
    int         stab_err = 0;
    int         low_run  = 0;
    int         min_gap  = 1000;
    logic       start_d  = 1'b0;

    assign bif.blk_valid = blk_valid;
    assign bif.blk_data  = blk_data;

    aes_block_uart_serializer #(
      .BLOCK_BYTES(16), .MSB_FIRST(g == 0), .GAP_CYCLES(2), .ACK_TIMEOUT(255)
    ) dut (
      .uart_clock(uart_clock), .uart_reset(uart_reset), .blk(bif.slave),
      .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
      .busy(busy), .byte_idx(byte_idx), .done(done), .err(err)
    );

    // Transmitter model: needs two low samples before a start, grabs the byte
    // two clocks after the start edge, and is busy for one frame.
    always @(posedge uart_clock or negedge uart_reset) begin
      if (!uart_reset) begin
        low_hist  <= 2'b00;
        busy_m    <= 1'b0;
        frame_cnt <= 0;
        tx_ready  <= 1'b1;
        lat       <= 8'h00;
      end else begin
        low_hist <= {low_hist[0], ~tx_start};
        if (!busy_m) begin
          if (tx_start && (low_hist == 2'b11) && !stuck) begin
            busy_m    <= 1'b1;
            tx_ready  <= 1'b0;
            frame_cnt <= 0;
            lat       <= tx_data;
            idx_q.push_back(byte_idx);
          end
        end else begin
          frame_cnt <= frame_cnt + 1;
          if (tx_data != lat) stab_err <= stab_err + 1;
          if (frame_cnt == 1) sent_q.push_back(tx_data);
          if (frame_cnt == FRAME - 1) begin
            busy_m   <= 1'b0;
            tx_ready <= 1'b1;
          end
        end
      end
    end

    // Counts done pulses and the shortest idle-low run seen before a start.
    always @(posedge uart_clock) begin
      start_d <= tx_start;
      if (done) done_cnt <= done_cnt + 1;
      if (tx_start && !start_d) begin
        if (low_run < min_gap) min_gap <= low_run;
        low_run <= 0;
      end else if (!tx_start && tx_ready) begin
        low_run <= low_run + 1;
      end else if (!tx_start) begin
        low_run <= 0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] q[$], input int base,
                             input logic [127:0] d, input bit msb);
    logic [7:0] got, want;
    for (int i = 0; i < 16; i++) begin
      want = msb ? d[127 - 8*i -: 8] : d[8*i +: 8];
      got  = (base + i < q.size()) ? q[base + i] : 8'hxx;
      check_val($sformatf("%s[%0d]", tag, i), {120'h0, got}, {120'h0, want});
    end
  endtask

  task automatic offer(input logic [127:0] d);
    @(negedge uart_clock);
    blk_data  = d;
    blk_valid = 1'b1;
    @(posedge uart_clock);
    #1;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge uart_clock);
      seen = ch[0].done;
    end
    check_val(tag, seen, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int b0, b1, i0, d0, hi;
    bit ok;
    #1 uart_reset = 1'b0;
    #1;
    check_val("rst_blk_ready", ch[0].bif.blk_ready, 1'b1);
    check_val("rst_tx_start", ch[0].tx_start, 1'b0);
    check_val("rst_tx_data", ch[0].tx_data, 8'h00);
    check_val("rst_busy", ch[0].busy, 1'b0);
    check_val("rst_byte_idx", ch[0].byte_idx, 4'd0);
    check_val("rst_done", ch[0].done, 1'b0);
    check_val("rst_err", ch[0].err, 1'b0);
    @(negedge uart_clock);
    uart_reset = 1'b1;

    // Single block, both byte orders at once.
    b0 = ch[0].sent_q.size(); b1 = ch[1].sent_q.size();
    i0 = ch[0].idx_q.size();  d0 = ch[0].done_cnt;
    offer(BLK_A);
    blk_valid = 1'b0;
    check_val("cap_busy", ch[0].busy, 1'b1);
    check_val("cap_ready_low", ch[0].bif.blk_ready, 1'b0);
    hi = 0;
    for (int i = 0; i < 10 && !ch[0].tx_start; i++) begin
      @(posedge uart_clock);
      #1;
      hi++;
    end
    check_val("first_start_latency", hi, 3);
    wait_done("blk_a_done");
    repeat (20) @(negedge uart_clock);
    check_val("blk_a_done_count", ch[0].done_cnt - d0, 1);
    check_val("blk_a_msb_count", ch[0].sent_q.size() - b0, 16);
    check_val("blk_a_lsb_count", ch[1].sent_q.size() - b1, 16);
    check_bytes("blk_a_msb", ch[0].sent_q, b0, BLK_A, 1'b1);
    check_bytes("blk_a_lsb", ch[1].sent_q, b1, BLK_A, 1'b0);
    for (int i = 0; i < 16; i++)
      check_val($sformatf("byte_idx[%0d]", i), ch[0].idx_q[i0 + i], i);

    // Back-to-back blocks with blk_valid held and blk_data churned while busy.
    b0 = ch[0].sent_q.size(); d0 = ch[0].done_cnt;
    offer(BLK_B1);
    check_val("b2b_cap1", ch[0].busy, 1'b1);
    for (int i = 0; i < 300; i++) begin
      @(negedge uart_clock);
      blk_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    @(negedge uart_clock);
    blk_data = BLK_B2;
    wait_done("b2b_done1");
    check_val("b2b_done_ready", ch[0].bif.blk_ready, 1'b1);
    @(posedge uart_clock);
    #1;
    check_val("b2b_cap2_busy", ch[0].busy, 1'b1);
    check_val("b2b_cap2_idx", ch[0].byte_idx, 4'd0);
    blk_valid = 1'b0;
    wait_done("b2b_done2");
    repeat (20) @(negedge uart_clock);
    check_val("b2b_done_count", ch[0].done_cnt - d0, 2);
    check_val("b2b_byte_count", ch[0].sent_q.size() - b0, 32);
    check_bytes("b2b_blk1", ch[0].sent_q, b0, BLK_B1, 1'b1);
    check_bytes("b2b_blk2", ch[0].sent_q, b0 + 16, BLK_B2, 1'b1);

    // Reset while byte 5 is being started, then a fresh block.
    offer(BLK_A);
    blk_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge uart_clock);
      ok = ch[0].tx_start && (ch[0].byte_idx == 4'd5);
    end
    check_val("reach_byte5", ok, 1'b1);
    #2 uart_reset = 1'b0;
    #1;
    check_val("midrst_tx_start", ch[0].tx_start, 1'b0);
    check_val("midrst_busy", ch[0].busy, 1'b0);
    check_val("midrst_blk_ready", ch[0].bif.blk_ready, 1'b1);
    check_val("midrst_byte_idx", ch[0].byte_idx, 4'd0);
    @(negedge uart_clock);
    uart_reset = 1'b1;
    b0 = ch[0].sent_q.size(); i0 = ch[0].idx_q.size(); d0 = ch[0].done_cnt;
    offer(BLK_C);
    blk_valid = 1'b0;
    wait_done("blk_c_done");
    repeat (20) @(negedge uart_clock);
    check_val("blk_c_done_count", ch[0].done_cnt - d0, 1);
    check_val("blk_c_count", ch[0].sent_q.size() - b0, 16);
    check_val("blk_c_first_idx", ch[0].idx_q[i0], 4'd0);
    check_bytes("blk_c", ch[0].sent_q, b0, BLK_C, 1'b1);

    // Transmitter never acknowledges: start must time out and flag err.
    stuck = 1'b1;
    d0 = ch[0].done_cnt;
    offer(BLK_A);
    blk_valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge uart_clock);
      if (ch[0].tx_start) hi++;
      else if (hi > 0) break;
    end
    check_val("ack_timeout_len", hi, 255);
    check_val("timeout_err", ch[0].err, 1'b1);
    check_val("timeout_blk_ready", ch[0].bif.blk_ready, 1'b1);
    check_val("timeout_busy", ch[0].busy, 1'b0);
    repeat (10) @(negedge uart_clock);
    check_val("timeout_no_done", ch[0].done_cnt - d0, 0);
    check_val("err_sticky", ch[0].err, 1'b1);
    stuck = 1'b0;
    offer(BLK_B2);
    blk_valid = 1'b0;
    check_val("err_cleared", ch[0].err, 1'b0);
    check_val("recover_busy", ch[0].busy, 1'b1);
    wait_done("recover_done");
    repeat (5) @(negedge uart_clock);
    check_val("recover_done_count", ch[0].done_cnt - d0, 1);

    check_val("gap_min_msb", ch[0].min_gap >= 2, 1'b1);
    check_val("gap_min_lsb", ch[1].min_gap >= 2, 1'b1);
    check_val("tx_data_stable_msb", ch[0].stab_err, 0);
    check_val("tx_data_stable_lsb", ch[1].stab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
